alu_share_arbiter: RTL and testbench

- Shares one mode-selected 8-bit ALU between two requesters.
- Arbitration is round-robin, with a request/acknowledge handshake on the input side and a valid/ready handshake on the result side.
- The ALU decodes modes the same way as the existing combinational mode ALU. The mul/div path runs multi-cycle; all other modes complete in one execute cycle.
- Sits between the two operand producers and a single result consumer.

---
 rtl/alu_share_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//
// Purpose:
//   Shares one mode-selected 8-bit ALU between two requesters. Arbitration is
//   round-robin. Operands are taken with a req/ack handshake, and the result is
//   handed to a single consumer with a valid/ready handshake. Mode 3'b011
//   (mul/div) takes MULDIV_LAT execute cycles; every other mode takes OTHER_LAT.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   req0/1     request; held high until the matching ack
//   mode0/1    operation select
//   a0/1, b0/1 operands
//   ack0/1     one-cycle pulse: operands accepted
//   res_ready  consumer can take the result
//   res_valid  res_data / res_id are valid
//   res_data   ALU result
//   res_id     requester that owns res_data
//   busy       high whenever the FSM is not idle
//
// Optional feature (macro ALU_ARB_STATS_EN):
//   Adds gnt_cnt0 / gnt_cnt1, saturating 16-bit per-requester grant counters.
//   With the macro undefined, these ports and counters do not exist.

module alu_share_arbiter #(
    parameter int unsigned MULDIV_LAT = 3,
    parameter int unsigned OTHER_LAT  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [2:0] mode0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    output logic       ack0,
    input  logic       req1,
    input  logic [2:0] mode1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    output logic       ack1,
    input  logic       res_ready,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_id,
    output logic       busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0] gnt_cnt0,
    output logic [15:0] gnt_cnt1
`endif
);

    // The counter is loaded with latency-1 and the result is taken when it hits 0.
    localparam logic [3:0] MulDivCnt = 4'(MULDIV_LAT - 1);
    localparam logic [3:0] OtherCnt  = 4'(OTHER_LAT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StHold
    } state_e;

    state_e     state_q, state_d;
    logic       last_q, last_d;     // requester granted most recently
    logic       gnt_q, gnt_d;       // owner of the operation in flight
    logic [2:0] mode_q, mode_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] ack_q, ack_d;
    logic       res_valid_q, res_valid_d;
    logic [7:0] res_data_q, res_data_d;
    logic       res_id_q, res_id_d;

    logic       win;
    logic [2:0] win_mode;
    logic       grant_fire;
    logic [7:0] alu_res;

    // Round-robin pick: a lone requester wins; on a tie the one not granted
    // last wins.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = ~last_q;
        end else begin
            win = req1;
        end
        win_mode   = win ? mode1 : mode0;
        grant_fire = (state_q == StIdle) && (req0 || req1);
    end

    // Shared ALU, operating on the latched operands.
    logic [15:0] prod;
    logic [7:0]  divisor;
    logic [7:0]  quot;

    always_comb begin
        prod    = {8'h00, a_q} * {8'h00, b_q};
        divisor = (b_q == 8'h00) ? 8'h01 : b_q;
        quot    = a_q / divisor;
        alu_res = a_q ^ b_q;
        case (mode_q)
            3'b001, 3'b010: alu_res = (a_q > b_q) ? (a_q + b_q) : (a_q - b_q);
            3'b011:         alu_res = (a_q < b_q) ? prod[7:0] : quot;
            3'b100:         alu_res = (a_q != b_q) ? ((a_q > b_q) ? a_q : b_q) : (a_q + b_q);
            default:        alu_res = a_q ^ b_q;
        endcase
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        mode_d      = mode_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        ack_d       = 2'b00;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;

        case (state_q)
            StIdle: begin
                if (grant_fire) begin
                    gnt_d   = win;
                    last_d  = win;
                    mode_d  = win_mode;
                    a_d     = win ? a1 : a0;
                    b_d     = win ? b1 : b0;
                    ack_d   = win ? 2'b10 : 2'b01;
                    cnt_d   = (win_mode == 3'b011) ? MulDivCnt : OtherCnt;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q == 4'd0) begin
                    res_data_d  = alu_res;
                    res_id_d    = gnt_q;
                    res_valid_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;    // so requester 0 wins the first tie
            gnt_q       <= 1'b0;
            mode_q      <= 3'b000;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            cnt_q       <= 4'd0;
            ack_q       <= 2'b00;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            res_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            mode_q      <= mode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign ack0      = ack_q[0];
    assign ack1      = ack_q[1];
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != StIdle);

`ifdef ALU_ARB_STATS_EN
    logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [15:0] gnt_cnt1_q, gnt_cnt1_d;

    always_comb begin
        gnt_cnt0_d = gnt_cnt0_q;
        gnt_cnt1_d = gnt_cnt1_q;
        if (grant_fire) begin
            if (!win && (gnt_cnt0_q != 16'hFFFF)) begin
                gnt_cnt0_d = gnt_cnt0_q + 16'd1;
            end
            if (win && (gnt_cnt1_q != 16'hFFFF)) begin
                gnt_cnt1_d = gnt_cnt1_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_cnt0_q <= 16'h0000;
            gnt_cnt1_q <= 16'h0000;
        end else begin
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//
// Directed bench for alu_share_arbiter. Expected results are pushed to a
// scoreboard queue when a request is driven and popped when res_valid rises.
// Define ALU_ARB_STATS_EN to also exercise the grant counters.

module tb_alu_share_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [2:0] mode0, mode1;
    logic [7:0] a0, b0, a1, b1;
    logic       ack0, ack1;
    logic       res_ready;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_id;
    logic       busy;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    alu_share_arbiter #(
        .MULDIV_LAT(3),
        .OTHER_LAT (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .mode0    (mode0),
        .a0       (a0),
        .b0       (b0),
        .ack0     (ack0),
        .req1     (req1),
        .mode1    (mode1),
        .a1       (a1),
        .b1       (b1),
        .ack1     (ack1),
        .res_ready(res_ready),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_id   (res_id),
        .busy     (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;

    function automatic logic [7:0] model(input logic [2:0] m, input logic [7:0] a,
                                         input logic [7:0] b);
        int unsigned ai, bi, r;
        ai = a;
        bi = b;
        case (m)
            3'b001, 3'b010: r = (ai > bi) ? ai + bi : ai - bi;
            3'b011:         r = (ai < bi) ? ai * bi : ai / ((bi == 0) ? 1 : bi);
            3'b100:         r = (ai != bi) ? ((ai > bi) ? ai : bi) : ai + bi;
            default:        r = ai ^ bi;
        endcase
        return r[7:0];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each result is checked on the cycle res_valid rises.
    task automatic monitor();
        exp_t e;
        if (res_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 16'(res_data), 16'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", 16'(res_data), 16'(e.data));
                chk("sb_id", 16'(res_id), 16'(e.id));
            end
        end
        prev_valid = res_valid;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic wait_ack(input logic id);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        do begin
            tick();
            n++;
            got = id ? ack1 : ack0;
        end while (!got && n < 40);
        chk(id ? "ack1_seen" : "ack0_seen", 16'(got), 16'd1);
    endtask

    task automatic issue(input logic id, input logic [2:0] m, input logic [7:0] a,
                         input logic [7:0] b);
        exp_t e;
        if (id) begin
            req1 = 1'b1; mode1 = m; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; mode0 = m; a0 = a; b0 = b;
        end
        e.id   = id;
        e.data = model(m, a, b);
        exp_q.push_back(e);
        wait_ack(id);
        if (id) req1 = 1'b0;
        else    req0 = 1'b0;
    endtask

    task automatic drain();
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 80) begin
            tick();
            n++;
            done = !busy && (exp_q.size() == 0);
        end
        chk("drain", 16'(done), 16'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        exp_t e;
        int   n;
        logic seen;

        rst = 1'b0;
        req0 = 1'b0; mode0 = 3'b000; a0 = 8'h00; b0 = 8'h00;
        req1 = 1'b0; mode1 = 3'b000; a1 = 8'h00; b1 = 8'h00;
        res_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_valid", 16'(res_valid), 16'd0);
        chk("rst_data", 16'(res_data), 16'h00);
        chk("rst_id", 16'(res_id), 16'd0);
        chk("rst_ack0", 16'(ack0), 16'd0);
        chk("rst_ack1", 16'(ack1), 16'd0);
        rst = 1'b1;

        // Reset during a mul/div EXEC: operation discarded, no result queued.
        req0 = 1'b1; mode0 = 3'b011; a0 = 8'd6; b0 = 8'd7;
        wait_ack(1'b0);
        req0 = 1'b0;
        tick();
        chk("midop_busy_before", 16'(busy), 16'd1);
        rst = 1'b0;
        tick();
        chk("midop_valid", 16'(res_valid), 16'd0);
        chk("midop_busy", 16'(busy), 16'd0);
        chk("midop_ack0", 16'(ack0), 16'd0);
        chk("midop_ack1", 16'(ack1), 16'd0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("midop_no_result", 16'(res_valid), 16'd0);

        // First tie after reset goes to requester 0.
        req0 = 1'b1; mode0 = 3'b111; a0 = 8'h11; b0 = 8'h22;
        req1 = 1'b1; mode1 = 3'b111; a1 = 8'h33; b1 = 8'h44;
        e.id = 1'b0; e.data = model(3'b111, 8'h11, 8'h22); exp_q.push_back(e);
        e.id = 1'b1; e.data = model(3'b111, 8'h33, 8'h44); exp_q.push_back(e);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(ack0 || ack1) && n < 40);
        chk("tie_ack0", 16'(ack0), 16'd1);
        chk("tie_ack1", 16'(ack1), 16'd0);
        req0 = 1'b0;
        wait_ack(1'b1);
        req1 = 1'b0;
        drain();

        // Single requester, mode 001, one-edge latency.
        issue(1'b0, 3'b001, 8'd9, 8'd4);
        tick();
        chk("m001_ack_once", 16'(ack0), 16'd0);
        chk("m001_valid_lat", 16'(res_valid), 16'd1);
        chk("m001_data", 16'(res_data), 16'd13);
        chk("m001_id", 16'(res_id), 16'd0);
        drain();
        issue(1'b0, 3'b001, 8'd4, 8'd9);
        tick();
        chk("m001_sub_data", 16'(res_data), 16'hFB);
        drain();

        // Mul/div on requester 1, three-edge latency.
        issue(1'b1, 3'b011, 8'd6, 8'd7);
        tick();
        chk("md_lat1", 16'(res_valid), 16'd0);
        tick();
        chk("md_lat2", 16'(res_valid), 16'd0);
        tick();
        chk("md_lat3", 16'(res_valid), 16'd1);
        chk("md_mul", 16'(res_data), 16'd42);
        drain();
        issue(1'b1, 3'b011, 8'd200, 8'd0);
        drain();
        issue(1'b1, 3'b011, 8'd20, 8'd3);
        drain();

        // Round-robin: both held high, grants alternate starting with 0.
        req0 = 1'b1; mode0 = 3'b111; a0 = 8'hF0; b0 = 8'h3C;
        req1 = 1'b1; mode1 = 3'b111; a1 = 8'h0F; b1 = 8'h0F;
        for (int k = 0; k < 4; k++) begin
            e.id   = 1'(k % 2);
            e.data = (k % 2 == 0) ? 8'hCC : 8'h00;
            exp_q.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!(ack0 || ack1) && n < 40);
            seen = ack0 || ack1;
            chk("rr_ack_seen", 16'(seen), 16'd1);
            chk("rr_gnt", 16'(ack1), 16'(k % 2));
        end
        req0 = 1'b0;
        req1 = 1'b0;
        drain();

        // Backpressure: result held while res_ready is low.
        res_ready = 1'b0;
        issue(1'b0, 3'b100, 8'd5, 8'd5);
        n = 0;
        do begin
            tick();
            n++;
        end while (!res_valid && n < 40);
        req1 = 1'b1; mode1 = 3'b001; a1 = 8'd3; b1 = 8'd1;
        e.id = 1'b1; e.data = model(3'b001, 8'd3, 8'd1); exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_valid", 16'(res_valid), 16'd1);
            chk("bp_data", 16'(res_data), 16'd10);
            chk("bp_no_ack1", 16'(ack1), 16'd0);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_handoff", 16'(res_valid), 16'd0);
        chk("bp_bubble", 16'(ack1), 16'd0);
        tick();
        chk("bp_ack1", 16'(ack1), 16'd1);
        req1 = 1'b0;
        drain();

`ifdef ALU_ARB_STATS_EN
        pulse_reset();
        chk("st_rst0", gnt_cnt0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 3'b000, 8'(i), 8'h01);
            drain();
        end
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 3'b000, 8'(i), 8'h02);
            drain();
        end
        chk("st_cnt0", gnt_cnt0, 16'd5);
        chk("st_cnt1", gnt_cnt1, 16'd3);
        force dut.gnt_cnt0_q = 16'hFFFF;
        tick();
        release dut.gnt_cnt0_q;
        issue(1'b0, 3'b000, 8'h01, 8'h01);
        drain();
        chk("st_sat", gnt_cnt0, 16'hFFFF);
        chk("st_cnt1_kept", gnt_cnt1, 16'd3);
`endif

        chk("sb_empty", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
